// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable controller: register address,
// CLKCTL field layout and the divider ratio encoding.
package clk_en_pkg;

  localparam logic [8:0] CLKCTL_ADDR  = 9'h058;

  localparam int         DIVA_LSB     = 0;
  localparam int         DIVS_LSB     = 4;
  localparam int         SELS_BIT     = 6;
  localparam logic [7:0] CLKCTL_WMASK = 8'h73;

  typedef enum logic [1:0] {
    DIV1 = 2'd0,
    DIV2 = 2'd1,
    DIV4 = 2'd2,
    DIV8 = 2'd3
  } div_e;

  // Low counter bits that must all be ones before a tick may fire.
  function automatic logic [2:0] div_mask(input logic [1:0] div);
    logic [2:0] mask;
    case (div)
      DIV1:    mask = 3'b000;
      DIV2:    mask = 3'b001;
      DIV4:    mask = 3'b011;
      DIV8:    mask = 3'b111;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Programmable /1,/2,/4,/8 tick divider producing a registered one-cycle
// enable. Used once for ACLK and once for SMCLK.
module clk_en_div
  import clk_en_pkg::*;
(
  input  logic       mclk,
  input  logic       puc,
  input  logic [1:0] div,
  input  logic       src_tick,
  input  logic       hold,
  input  logic       clear,
  output logic       en
);

  logic [2:0] cnt;
  logic       match;

  assign match = &(cnt | ~div_mask(div));

  // Clear beats a coincident tick so a reconfigured period always restarts
  // from zero; hold freezes the count while the clock is gated.
  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      cnt <= 3'd0;
      en  <= 1'b0;
    end else if (clear) begin
      cnt <= 3'd0;
      en  <= 1'b0;
    end else if (hold) begin
      en  <= 1'b0;
    end else begin
      en <= src_tick & match;
      if (src_tick) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: derives the ACLK and SMCLK tick strobes on the
// mclk domain from a synchronized LFXT input and a single control register.
module clk_en_ctrl #(
  parameter logic [8:0] CLKCTL_ADDR = clk_en_pkg::CLKCTL_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        mclk,
  input  logic        puc,
  input  logic        lfxt_clk,
  input  logic        oscoff,
  input  logic        scg1,
  input  logic [7:0]  per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_wen,
  output logic [15:0] per_dout,
  output logic        aclk_en,
  output logic        smclk_en
);

  import clk_en_pkg::*;

  logic [7:0]             clkctl;
  logic                   reg_sel;
  logic                   reg_wr;
  logic                   reg_rd;
  logic [SYNC_STAGES-1:0] lfxt_sync;
  logic                   edge_q;
  logic                   sync_out;
  logic                   lfxt_tick;
  logic                   lfxt_src;
  logic                   sels;
  logic                   smclk_src;
  logic                   smclk_hold;
  logic                   unused_din;

  assign unused_din = ^per_din[15:8];

  // The bus carries word addresses, so only the upper address bits compare.
  assign reg_sel  = per_en & (per_addr == CLKCTL_ADDR[8:1]);
  assign reg_wr   = reg_sel & per_wen[0];
  assign reg_rd   = reg_sel & ~|per_wen;
  assign per_dout = reg_rd ? {8'h00, clkctl} : 16'h0000;

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      clkctl <= 8'h00;
    end else if (reg_wr) begin
      clkctl <= per_din[7:0] & CLKCTL_WMASK;
    end
  end

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      lfxt_sync <= '0;
      edge_q    <= 1'b0;
    end else begin
      lfxt_sync <= {lfxt_sync[SYNC_STAGES-2:0], lfxt_clk};
      edge_q    <= lfxt_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out  = lfxt_sync[SYNC_STAGES-1];
  assign lfxt_tick = sync_out & ~edge_q;
  assign lfxt_src  = lfxt_tick & ~oscoff;

  // SMCLK runs every cycle from mclk; when fed from LFXT it is also frozen
  // by oscoff so its count holds exactly like ACLK's.
  assign sels       = clkctl[SELS_BIT];
  assign smclk_src  = sels ? lfxt_src : 1'b1;
  assign smclk_hold = scg1 | (sels & oscoff);

  clk_en_div u_aclk_div (
    .mclk     (mclk),
    .puc      (puc),
    .div      (clkctl[DIVA_LSB +: 2]),
    .src_tick (lfxt_src),
    .hold     (oscoff),
    .clear    (reg_wr),
    .en       (aclk_en)
  );

  clk_en_div u_smclk_div (
    .mclk     (mclk),
    .puc      (puc),
    .div      (clkctl[DIVS_LSB +: 2]),
    .src_tick (smclk_src),
    .hold     (smclk_hold),
    .clear    (reg_wr),
    .en       (smclk_en)
  );

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed self-checking bench for clk_en_ctrl: reset, both dividers, gating,
// register bus behaviour and the write/tick collision.
module tb_clk_en_ctrl;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] REG_ADDR    = 8'h2C;

  logic        mclk = 1'b0;
  logic        puc;
  logic        lfxt_clk;
  logic        oscoff;
  logic        scg1;
  logic [7:0]  per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_wen;
  logic [15:0] per_dout;
  logic        aclk_en;
  logic        smclk_en;

  int checks = 0;
  int passed = 0;

  int   ncyc = 0;
  int   pcyc = 0;
  int   a_cnt = 0;
  int   s_cnt = 0;
  int   a_last = 0;
  int   a_consec = 0;
  logic prev_a = 1'b0;

  clk_en_ctrl #(
    .CLKCTL_ADDR (9'h058),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .mclk     (mclk),
    .puc      (puc),
    .lfxt_clk (lfxt_clk),
    .oscoff   (oscoff),
    .scg1     (scg1),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_wen  (per_wen),
    .per_dout (per_dout),
    .aclk_en  (aclk_en),
    .smclk_en (smclk_en)
  );

  always #5 mclk = ~mclk;

  // pcyc numbers rising edges; the falling-edge monitor tallies strobes.
  always @(posedge mclk) pcyc++;

  always @(negedge mclk) begin
    ncyc++;
    if (aclk_en) begin
      a_cnt++;
      a_last = ncyc;
      if (prev_a) a_consec++;
    end
    if (smclk_en) s_cnt++;
    prev_a = aclk_en;
  end

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data,
                           input logic [1:0] wen);
    @(posedge mclk); #1;
    per_en = 1'b1; per_addr = addr; per_din = data; per_wen = wen;
    @(posedge mclk); #1;
    per_en = 1'b0; per_wen = 2'b00; per_din = 16'h0000;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [15:0] data);
    #1;
    per_en = 1'b1; per_addr = addr; per_wen = 2'b00;
    #1;
    data = per_dout;
    per_en = 1'b0;
  endtask

  // One 10-cycle LFXT period: high for 5 mclk, low for 5 mclk.
  task automatic lfxt_period(output int a_n, output int s_n, output int rise);
    int a0, s0;
    a0 = a_cnt; s0 = s_cnt;
    @(posedge mclk); #1;
    lfxt_clk = 1'b1;
    rise = ncyc;
    repeat (5) @(posedge mclk);
    #1 lfxt_clk = 1'b0;
    repeat (4) @(posedge mclk);
    #1;
    a_n = a_cnt - a0; s_n = s_cnt - s0;
  endtask

  // Same period, with a CLKCTL write landing on the edge that consumes the tick.
  task automatic lfxt_period_wr(input logic [15:0] data, output int a_n);
    int a0;
    a0 = a_cnt;
    @(posedge mclk); #1;
    lfxt_clk = 1'b1;
    repeat (2) @(posedge mclk);
    #1;
    per_en = 1'b1; per_addr = REG_ADDR; per_din = data; per_wen = 2'b01;
    @(posedge mclk); #1;
    per_en = 1'b0; per_wen = 2'b00;
    repeat (2) @(posedge mclk);
    #1 lfxt_clk = 1'b0;
    repeat (4) @(posedge mclk);
    #1;
    a_n = a_cnt - a0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    repeat (3) @(negedge mclk);
    checks++; if (aclk_en !== 1'b0) $display("[TB] FAIL rst_aclk: got %b want 0", aclk_en); else passed++;
    checks++; if (smclk_en !== 1'b0) $display("[TB] FAIL rst_smclk: got %b want 0", smclk_en); else passed++;
    puc = 1'b0;
    @(negedge mclk);
    checks++; if (smclk_en !== 1'b1) $display("[TB] FAIL rel_smclk: got %b want 1", smclk_en); else passed++;
    bus_read(REG_ADDR, rd);
    checks++; if (rd !== 16'h0000) $display("[TB] FAIL rel_clkctl: got %h want 0000", rd); else passed++;
    bus_write(REG_ADDR, 16'h0003, 2'b11);
    bus_read(REG_ADDR, rd);
    checks++; if (rd !== 16'h0003) $display("[TB] FAIL pre_rst_clkctl: got %h want 0003", rd); else passed++;
    repeat (3) @(negedge mclk);
    checks++; if (smclk_en !== 1'b1) $display("[TB] FAIL run_smclk: got %b want 1", smclk_en); else passed++;
    #2 puc = 1'b1;
    #1;
    checks++; if (smclk_en !== 1'b0) $display("[TB] FAIL async_smclk: got %b want 0", smclk_en); else passed++;
    checks++; if (aclk_en !== 1'b0) $display("[TB] FAIL async_aclk: got %b want 0", aclk_en); else passed++;
    @(negedge mclk);
    puc = 1'b0;
    @(negedge mclk);
    checks++; if (smclk_en !== 1'b1) $display("[TB] FAIL rel2_smclk: got %b want 1", smclk_en); else passed++;
    bus_read(REG_ADDR, rd);
    checks++; if (rd !== 16'h0000) $display("[TB] FAIL post_rst_clkctl: got %h want 0000", rd); else passed++;
  endtask

  task automatic test_smclk_mclk();
    int w, e, first, bad;
    logic want;
    bus_write(REG_ADDR, 16'h0020, 2'b11);
    w = pcyc;
    first = -1; bad = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge mclk);
      e = pcyc - w;
      want = (e > 0) && (e % 4 == 0);
      if (smclk_en !== want) bad++;
      if (smclk_en && first < 0) first = e;
    end
    checks++; if (first !== 4) $display("[TB] FAIL smclk_first: got edge %0d want edge 4", first); else passed++;
    checks++; if (bad !== 0) $display("[TB] FAIL smclk_every4: got %0d wrong cycles want 0", bad); else passed++;
  endtask

  task automatic test_aclk_div();
    int a_n, s_n, r, r8, first, bad, c0;
    bus_write(REG_ADDR, 16'h0003, 2'b11);
    bad = 0; r8 = 0; first = 0; c0 = a_consec;
    for (int p = 1; p <= 16; p++) begin
      lfxt_period(a_n, s_n, r);
      if (a_n !== ((p == 8 || p == 16) ? 1 : 0)) bad++;
      if (p == 8) begin
        r8 = r;
        first = a_last;
      end
    end
    checks++; if (bad !== 0) $display("[TB] FAIL aclk_div8_pattern: got %0d wrong periods want 0", bad); else passed++;
    checks++; if (first - r8 !== SYNC_STAGES + 2) $display("[TB] FAIL aclk_latency: got %0d want %0d", first - r8, SYNC_STAGES + 2); else passed++;
    checks++; if (a_last - first !== 80) $display("[TB] FAIL aclk_period: got %0d want 80", a_last - first); else passed++;
    checks++; if (a_consec - c0 !== 0) $display("[TB] FAIL aclk_single: got %0d doubled pulses want 0", a_consec - c0); else passed++;
  endtask

  task automatic test_smclk_lfxt_gating();
    int a_n, s_n, r, s_bad, a_bad;
    bus_write(REG_ADDR, 16'h0050, 2'b11);
    s_bad = 0;
    for (int p = 1; p <= 3; p++) begin
      lfxt_period(a_n, s_n, r);
      if (s_n !== ((p == 2) ? 1 : 0)) s_bad++;
    end
    checks++; if (s_bad !== 0) $display("[TB] FAIL smclk_lfxt_div2: got %0d wrong periods want 0", s_bad); else passed++;
    scg1 = 1'b1;
    s_bad = 0; a_bad = 0;
    for (int p = 0; p < 3; p++) begin
      lfxt_period(a_n, s_n, r);
      if (s_n !== 0) s_bad++;
      if (a_n !== 1) a_bad++;
    end
    checks++; if (s_bad !== 0) $display("[TB] FAIL scg1_gate: got %0d pulsing periods want 0", s_bad); else passed++;
    checks++; if (a_bad !== 0) $display("[TB] FAIL scg1_aclk: got %0d wrong periods want 0", a_bad); else passed++;
    scg1 = 1'b0;
    lfxt_period(a_n, s_n, r);
    checks++; if (s_n !== 1) $display("[TB] FAIL scg1_held: got %0d pulses want 1", s_n); else passed++;
    oscoff = 1'b1;
    a_bad = 0; s_bad = 0;
    for (int p = 0; p < 2; p++) begin
      lfxt_period(a_n, s_n, r);
      if (a_n !== 0) a_bad++;
      if (s_n !== 0) s_bad++;
    end
    checks++; if (a_bad !== 0) $display("[TB] FAIL oscoff_aclk: got %0d pulsing periods want 0", a_bad); else passed++;
    checks++; if (s_bad !== 0) $display("[TB] FAIL oscoff_smclk: got %0d pulsing periods want 0", s_bad); else passed++;
    oscoff = 1'b0;
    lfxt_period(a_n, s_n, r);
    checks++; if (a_n !== 1) $display("[TB] FAIL oscoff_rel_aclk: got %0d pulses want 1", a_n); else passed++;
    checks++; if (s_n !== 0) $display("[TB] FAIL oscoff_rel_smclk: got %0d pulses want 0", s_n); else passed++;
  endtask

  task automatic test_bus();
    logic [15:0] rd;
    bus_write(REG_ADDR, 16'hFFFF, 2'b11);
    bus_read(REG_ADDR, rd);
    checks++; if (rd !== 16'h0073) $display("[TB] FAIL bus_mask: got %h want 0073", rd); else passed++;
    bus_write(REG_ADDR, 16'h0000, 2'b10);
    bus_read(REG_ADDR, rd);
    checks++; if (rd !== 16'h0073) $display("[TB] FAIL bus_hi_only: got %h want 0073", rd); else passed++;
    bus_read(8'h2D, rd);
    checks++; if (rd !== 16'h0000) $display("[TB] FAIL bus_other_addr: got %h want 0000", rd); else passed++;
    #1 per_addr = REG_ADDR; per_en = 1'b0; per_wen = 2'b00;
    #1;
    checks++; if (per_dout !== 16'h0000) $display("[TB] FAIL bus_idle: got %h want 0000", per_dout); else passed++;
    per_en = 1'b1; per_wen = 2'b10;
    #1;
    checks++; if (per_dout !== 16'h0000) $display("[TB] FAIL bus_write_no_read: got %h want 0000", per_dout); else passed++;
    per_en = 1'b0; per_wen = 2'b00;
  endtask

  task automatic test_collision();
    int a_n, s_n, r;
    bus_write(REG_ADDR, 16'h0001, 2'b11);
    lfxt_period(a_n, s_n, r);
    checks++; if (a_n !== 0) $display("[TB] FAIL coll_pre: got %0d pulses want 0", a_n); else passed++;
    lfxt_period_wr(16'h0001, a_n);
    checks++; if (a_n !== 0) $display("[TB] FAIL coll_tick: got %0d pulses want 0", a_n); else passed++;
    lfxt_period(a_n, s_n, r);
    checks++; if (a_n !== 0) $display("[TB] FAIL coll_restart: got %0d pulses want 0", a_n); else passed++;
    lfxt_period(a_n, s_n, r);
    checks++; if (a_n !== 1) $display("[TB] FAIL coll_resume: got %0d pulses want 1", a_n); else passed++;
  endtask

  initial begin
    puc      = 1'b1;
    lfxt_clk = 1'b0;
    oscoff   = 1'b0;
    scg1     = 1'b0;
    per_addr = 8'h00;
    per_din  = 16'h0000;
    per_en   = 1'b0;
    per_wen  = 2'b00;
    test_reset();
    test_smclk_mclk();
    test_aclk_div();
    test_smclk_lfxt_gating();
    test_bus();
    test_collision();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
